// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit-FIFO pop FSM states and default sizing.
package uart_pkg;

  localparam int unsigned WIDTH_DATA_DEF = 8;
  localparam int unsigned DEPTH_LOG2_DEF = 4;

  typedef enum logic [1:0] {
    TXF_IDLE,
    TXF_LOAD,
    TXF_BUSY
  } txf_state_t;

endpackage

// File: rtl/tx_fifo_if.sv
// Host-write / transmitter-handshake bundle of the UART transmit FIFO.
interface tx_fifo_if
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH_DATA = WIDTH_DATA_DEF,
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF
);

  logic                  i_we;
  logic [WIDTH_DATA-1:0] i_data;
  logic                  o_full;
  logic                  o_empty;
  logic [DEPTH_LOG2:0]   o_count;
  logic                  o_ovf;
  logic                  o_tx_we;
  logic [WIDTH_DATA-1:0] o_tx_data;
  logic                  i_tx_mty;

  modport slave (
    input  i_we, i_data, i_tx_mty,
    output o_full, o_empty, o_count, o_ovf, o_tx_we, o_tx_data
  );

  modport master (
    output i_we, i_data, i_tx_mty,
    input  o_full, o_empty, o_count, o_ovf, o_tx_we, o_tx_data
  );

endinterface

// File: rtl/fifo_mem.sv
// Storage array for tx_fifo: synchronous write, asynchronous read.
module fifo_mem
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH_DATA = WIDTH_DATA_DEF,
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_waddr,
  input  logic [WIDTH_DATA-1:0] i_wdata,
  input  logic [DEPTH_LOG2-1:0] i_raddr,
  output logic [WIDTH_DATA-1:0] o_rdata
);

  logic [WIDTH_DATA-1:0] mem_q [2**DEPTH_LOG2];

  always_ff @(posedge i_clk) begin
    if (i_we) mem_q[i_waddr] <= i_wdata;
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/tx_fifo.sv
// Transmit FIFO feeding the UART transmitter one byte per transmitter idle phase.
// Define TX_FIFO_OVF_EN to build the sticky overflow flag; otherwise o_ovf is tied low.
module tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH_DATA = WIDTH_DATA_DEF,
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input logic      i_clk,
  input logic      i_rst,
  tx_fifo_if.slave bus
);

  localparam int unsigned         DEPTH    = 2**DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);

  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  txf_state_t            state_q, state_d;
  logic                  tx_we_q, tx_we_d;
  logic [WIDTH_DATA-1:0] tx_data_q, tx_data_d;
  logic [WIDTH_DATA-1:0] rd_data;
  logic                  push;
  logic                  pop;

  fifo_mem #(
    .WIDTH_DATA (WIDTH_DATA),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (push),
    .i_waddr (wptr_q),
    .i_wdata (bus.i_data),
    .i_raddr (rptr_q),
    .o_rdata (rd_data)
  );

  // Push is gated by the registered full flag, so a same-cycle pop never frees a slot for it.
  always_comb begin
    push    = bus.i_we && !full_q;
    pop     = (state_q == TXF_IDLE) && !empty_q && bus.i_tx_mty;
    wptr_d  = push ? wptr_q + DEPTH_LOG2'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + DEPTH_LOG2'(1) : rptr_q;
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (DEPTH_LOG2+1)'(1);
      2'b01:   count_d = count_q - (DEPTH_LOG2+1)'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CNT_FULL);
    empty_d = (count_d == '0);
  end

  always_comb begin
    state_d   = state_q;
    tx_we_d   = 1'b0;
    tx_data_d = tx_data_q;
    unique case (state_q)
      TXF_IDLE: begin
        if (pop) begin
          tx_we_d   = 1'b1;
          tx_data_d = rd_data;
          state_d   = TXF_LOAD;
        end
      end
      TXF_LOAD: if (!bus.i_tx_mty) state_d = TXF_BUSY;
      TXF_BUSY: if (bus.i_tx_mty)  state_d = TXF_IDLE;
      default:  state_d = TXF_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      state_q   <= TXF_IDLE;
      tx_we_q   <= 1'b0;
      tx_data_q <= '1;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      state_q   <= state_d;
      tx_we_q   <= tx_we_d;
      tx_data_q <= tx_data_d;
    end
  end

`ifdef TX_FIFO_OVF_EN
  logic ovf_q, ovf_d;

  always_comb ovf_d = ovf_q || (bus.i_we && full_q);

  always_ff @(posedge i_clk) begin
    if (i_rst) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign bus.o_ovf = ovf_q;
`else
  assign bus.o_ovf = 1'b0;
`endif

  assign bus.o_full    = full_q;
  assign bus.o_empty   = empty_q;
  assign bus.o_count   = count_q;
  assign bus.o_tx_we   = tx_we_q;
  assign bus.o_tx_data = tx_data_q;

endmodule

// File: tb/tb_tx_fifo.sv
// Scoreboard bench for tx_fifo: accepted bytes are queued and matched against each o_tx_we pulse.
module tb_tx_fifo;

`ifdef TX_FIFO_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  tx_fifo_if #(.WIDTH_DATA(8), .DEPTH_LOG2(4)) bus ();

  tx_fifo #(.WIDTH_DATA(8), .DEPTH_LOG2(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  logic [7:0]  sb [$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned n_pulses = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Every transmitter load must carry the oldest outstanding accepted byte.
  always @(negedge clk) begin
    if (bus.o_tx_we === 1'b1) begin
      n_pulses++;
      check_eq("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) check_eq("tx_data_order", 32'(bus.o_tx_data), 32'(sb.pop_front()));
    end
  end

  task automatic tick(input int unsigned n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic write(input logic [7:0] d, input bit accept);
    bus.i_we   = 1'b1;
    bus.i_data = d;
    if (accept) sb.push_back(d);
    tick();
    bus.i_we = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_empty"},   32'(bus.o_empty),   32'd1);
    check_eq({tag, "_count"},   32'(bus.o_count),   32'd0);
    check_eq({tag, "_full"},    32'(bus.o_full),    32'd0);
    check_eq({tag, "_tx_we"},   32'(bus.o_tx_we),   32'd0);
    check_eq({tag, "_tx_data"}, 32'(bus.o_tx_data), 32'hFF);
    check_eq({tag, "_ovf"},     32'(bus.o_ovf),     32'd0);
  endtask

  // Transmitter model: go idle, take one byte, stay busy for 'low' cycles.
  task automatic drain(input int unsigned n, input int unsigned low);
    for (int unsigned k = 0; k < n; k++) begin
      int unsigned snap;
      bit          seen;
      snap = n_pulses;
      seen = 1'b0;
      bus.i_tx_mty = 1'b1;
      for (int unsigned t = 0; t < 10 && !seen; t++) begin
        tick();
        seen = bus.o_tx_we;
      end
      check_eq("pulse_seen", 32'(seen), 32'd1);
      bus.i_tx_mty = 1'b0;
      tick(low);
      check_eq("one_pulse_per_busy", n_pulses - snap, 32'd1);
    end
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned snap;

    rst          = 1'b1;
    bus.i_we     = 1'b0;
    bus.i_data   = '0;
    bus.i_tx_mty = 1'b0;

    // Reset values
    tick(2);
    check_reset_state("rst");
    rst = 1'b0;

    // Single byte with transmitter idle: pulse exactly two edges after acceptance
    bus.i_tx_mty = 1'b1;
    write(8'hA5, 1'b1);
    check_eq("single_we_n1",    32'(bus.o_tx_we),   32'd0);
    check_eq("single_count_n1", 32'(bus.o_count),   32'd1);
    check_eq("single_empty_n1", 32'(bus.o_empty),   32'd0);
    tick();
    check_eq("single_we_n2",    32'(bus.o_tx_we),   32'd1);
    check_eq("single_data_n2",  32'(bus.o_tx_data), 32'hA5);
    check_eq("single_count_n2", 32'(bus.o_count),   32'd0);
    tick();
    check_eq("single_we_n3",    32'(bus.o_tx_we),   32'd0);
    check_eq("single_empty_n3", 32'(bus.o_empty),   32'd1);
    check_eq("single_data_hold", 32'(bus.o_tx_data), 32'hA5);

    // Fill to 16 with transmitter busy, then overflow attempt
    bus.i_tx_mty = 1'b0;
    tick(2);
    for (int unsigned i = 0; i < 16; i++) begin
      write(8'(8'h10 + i), 1'b1);
      if (i == 14) check_eq("fill_full_at15", 32'(bus.o_full), 32'd0);
    end
    check_eq("fill_full",  32'(bus.o_full),  32'd1);
    check_eq("fill_count", 32'(bus.o_count), 32'd16);
    check_eq("fill_ovf_before", 32'(bus.o_ovf), 32'd0);
    write(8'h3C, 1'b0);
    check_eq("ovf_count", 32'(bus.o_count), 32'd16);
    check_eq("ovf_full",  32'(bus.o_full),  32'd1);
    check_eq("ovf_flag",  32'(bus.o_ovf),   32'(OVF_EN));
    drain(16, 2);
    check_eq("drained_empty", 32'(bus.o_empty), 32'd1);
    check_eq("ovf_sticky",    32'(bus.o_ovf),   32'(OVF_EN));

    // Ordering under long transmitter busy phases
    write(8'h01, 1'b1);
    write(8'h02, 1'b1);
    write(8'h03, 1'b1);
    check_eq("order_count", 32'(bus.o_count), 32'd3);
    drain(3, 20);
    check_eq("order_sb_empty", 32'(sb.size()), 32'd0);

    // Simultaneous push and pop at occupancy 1
    bus.i_tx_mty = 1'b1;
    tick(3);
    check_eq("pp_idle_empty", 32'(bus.o_empty), 32'd1);
    write(8'h55, 1'b1);
    check_eq("pp_count_before", 32'(bus.o_count), 32'd1);
    check_eq("pp_we_before",    32'(bus.o_tx_we), 32'd0);
    write(8'h66, 1'b1);
    check_eq("pp_count_after", 32'(bus.o_count),   32'd1);
    check_eq("pp_we_after",    32'(bus.o_tx_we),   32'd1);
    check_eq("pp_data_after",  32'(bus.o_tx_data), 32'h55);
    bus.i_tx_mty = 1'b0;
    tick(3);
    drain(1, 2);

    // Reset mid-operation with FSM busy and 5 entries held
    for (int unsigned i = 0; i < 5; i++) write(8'(8'hC0 + i), 1'b0);
    check_eq("mid_count", 32'(bus.o_count), 32'd5);
    rst = 1'b1;
    tick();
    check_reset_state("midrst");
    rst = 1'b0;
    sb.delete();
    bus.i_tx_mty = 1'b1;
    snap = n_pulses;
    tick(10);
    check_eq("midrst_no_pulse", n_pulses - snap, 32'd0);
    check_eq("midrst_empty",    32'(bus.o_empty), 32'd1);
    check_eq("midrst_count",    32'(bus.o_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
